rgb_sinp_word: RTL and testbench

- Parametrised successor to the single-bit RGB serial input decoder.
- Decodes a WS2812-style one-wire NRZ stream (high-time-coded bits, long idle = stream reset) into complete pixel words of BITS_PER_PIXEL bits (24 RGB or 32 RGBW).
- Buffers decoded words in a small FIFO with a valid/ready output handshake.
- Sits between the input pin and the RGB->RGBW conversion path; adds glitch rejection, error resynchronisation and overflow reporting.

---
 rtl/rgb_sinp_word.sv | 202 ++++++++++++++++++++
 tb/tb_rgb_sinp_word.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sinp_word.sv
// rgb_sinp_word -- WS2812-style one-wire NRZ decoder producing whole pixel words.
//
// The high time of each pulse codes one bit: long high = 1, short high = 0, and
// a high pulse that is too short is a glitch. A long constant line level, high
// or low, is a stream reset. Bits are assembled MSB first into BITS_PER_PIXEL
// words. Each word is queued in a small first-word-fall-through FIFO behind a
// valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sig          raw serial input, asynchronous to clk
//   pix_data     head-of-FIFO pixel word
//   pix_first    head word is the first word after reset / stream reset
//   pix_valid    head word is valid
//   pix_ready    consumer accepts head word when pix_valid && pix_ready
//   stream_reset one-cycle pulse when a stream reset is detected
//   bit_err      one-cycle pulse when a glitch (too-short high) is seen
//   overflow     one-cycle pulse when a completed word is dropped (FIFO full)
module rgb_sinp_word #(
  parameter int BITS_PER_PIXEL    = 24,
  parameter int COUNTER_MAX       = 5000,
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int SAMPLE_TIME_CLKS  = 57,
  parameter int MIN_HIGH_CLKS     = 24,
  parameter int SYNC_STAGES       = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sig,
  output logic [BITS_PER_PIXEL-1:0] pix_data,
  output logic                      pix_first,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      stream_reset,
  output logic                      bit_err,
  output logic                      overflow
);

  localparam int CW = $clog2(COUNTER_MAX + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic                      first;
    logic [BITS_PER_PIXEL-1:0] data;
  } pix_word_t;

  typedef enum logic [1:0] {IDLE, HIGH, RESYNC, WAIT_LOW} state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection. The decoder works on a flopped copy of the
  // synchronised level (lvl) and compares it with its own delayed copy, so the
  // level, the edge strobes and the counter all come straight from flops.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl, lvl_d;
  logic                   rise, fall, lvl_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl    <= 1'b0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      lvl    <= sync_q[SYNC_STAGES-1];
      lvl_d  <= lvl;
    end
  end

  assign rise     = lvl & ~lvl_d;
  assign fall     = ~lvl & lvl_d;
  assign lvl_edge = lvl ^ lvl_d;

  // ---------------------------------------------------------------------------
  // Level-time counter. On the cycle of an edge it holds the length of the
  // level that just ended, so on a fall it is exactly the high time.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (lvl_edge)                 cnt <= CW'(1);
    else if (cnt != CW'(COUNTER_MAX))  cnt <= cnt + CW'(1);
  end

  // The counter reaches the threshold on the next edge. It saturates above
  // the threshold, so one idle period gives only one hit.
  logic sr_hit;
  assign sr_hit = !lvl_edge && (cnt == CW'(STREAM_RESET_CLKS - 1));

  // ---------------------------------------------------------------------------
  // Bit decoder
  // ---------------------------------------------------------------------------
  state_t                    state;
  logic [BITS_PER_PIXEL-2:0] sreg;
  logic [BW-1:0]             bcnt;
  logic                      first_q;

  logic      glitch, take, bit_val, word_done;
  pix_word_t push_word;

  always_comb begin
    glitch    = (state == HIGH) && fall && (cnt < CW'(MIN_HIGH_CLKS));
    take      = (state == HIGH) && fall && !glitch;
    bit_val   = (cnt >= CW'(SAMPLE_TIME_CLKS));
    word_done = take && (bcnt == BW'(BITS_PER_PIXEL - 1));
    push_word       = '0;
    push_word.first = first_q;
    push_word.data  = {sreg, bit_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      bcnt         <= '0;
      first_q      <= 1'b1;
      stream_reset <= 1'b0;
      bit_err      <= 1'b0;
    end else begin
      stream_reset <= sr_hit;
      bit_err      <= glitch;
      if (sr_hit) begin
        // A partial word is dropped. A line held high must fall before the
        // next bit can start.
        bcnt    <= '0;
        first_q <= 1'b1;
        state   <= lvl ? WAIT_LOW : IDLE;
      end else begin
        case (state)
          IDLE:     if (rise) state <= HIGH;
          HIGH: begin
            if (fall) begin
              if (glitch) begin
                sreg  <= '0;
                bcnt  <= '0;
                state <= RESYNC;
              end else begin
                sreg  <= {sreg[BITS_PER_PIXEL-3:0], bit_val};
                state <= IDLE;
                if (word_done) begin
                  bcnt    <= '0;
                  first_q <= 1'b0;
                end else begin
                  bcnt    <= bcnt + BW'(1);
                end
              end
            end
          end
          RESYNC:   ;  // only a stream reset leaves this state
          WAIT_LOW: if (fall) state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO, first-word-fall-through. When the FIFO is full, a push is still
  // taken if the head is popped in the same cycle.
  // ---------------------------------------------------------------------------
  pix_word_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic          full, pop, push_ok, drop;

  assign full      = (occ == OW'(FIFO_DEPTH));
  assign pix_valid = (occ != '0);
  assign pop       = pix_valid && pix_ready;
  assign push_ok   = word_done && (!full || pop);
  assign drop      = word_done && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  assign pix_data  = mem[rd_ptr].data;
  assign pix_first = mem[rd_ptr].first;

endmodule

// File: tb/tb_rgb_sinp_word.sv
// Directed bench for rgb_sinp_word. It drives a 24-bit instance and a 32-bit
// instance. Expected words go into a scoreboard queue when stimulus is sent and
// are compared as the consumer pops them.
module tb_rgb_sinp_word;
  localparam int BPP  = 24;
  localparam int SYNC = 2;
  localparam int SRC  = 4800;

  logic           clk = 1'b0, rst_n = 1'b0, sig = 1'b0, pix_ready = 1'b0;
  logic [BPP-1:0] pix_data;
  logic           pix_first, pix_valid, stream_reset, bit_err, overflow;
  logic           sig32 = 1'b0, ready32 = 1'b1;
  logic [31:0]    pix_data32;
  logic           pix_first32, pix_valid32, sr32, berr32, ovf32;

  rgb_sinp_word #(.BITS_PER_PIXEL(BPP)) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .pix_data(pix_data), .pix_first(pix_first),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .stream_reset(stream_reset),
    .bit_err(bit_err), .overflow(overflow));

  rgb_sinp_word #(.BITS_PER_PIXEL(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .sig(sig32), .pix_data(pix_data32), .pix_first(pix_first32),
    .pix_valid(pix_valid32), .pix_ready(ready32), .stream_reset(sr32),
    .bit_err(berr32), .overflow(ovf32));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_sr = 0, n_berr = 0, n_ovf = 0, n_v = 0, sr_cyc = 0;
  int n_sr32 = 0, n_v32 = 0;
  logic [32:0]  last32 = '0;
  logic [BPP:0] sb[$];
  logic         stall_q = 1'b0;
  logic [BPP:0] hold_w = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples 1 time unit after the falling edge, so it sees
  // this cycle's pix_ready together with the outputs that were registered
  // on the previous rising edge.
  always @(negedge clk) begin
    logic [BPP:0] e;
    #1;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("hold_stable", {pix_first, pix_data}, hold_w);
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) check("sb_unexpected_word", 64'(sb.size() != 0), 64'd1);
        else begin
          e = sb.pop_front();
          check("word", {pix_first, pix_data}, e);
        end
      end
      stall_q = pix_valid && !pix_ready;
      hold_w  = {pix_first, pix_data};
      if (pix_valid)    n_v++;
      if (stream_reset) begin n_sr++; sr_cyc = cyc; end
      if (bit_err)      n_berr++;
      if (overflow)     n_ovf++;
      if (pix_valid32) begin n_v32++; last32 = {pix_first32, pix_data32}; end
      if (sr32)         n_sr32++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit w32, input logic v);
    if (w32) sig32 = v; else sig = v;
  endtask

  task automatic send_hl(input bit w32, input int h, input int l);
    drive(w32, 1'b1); wait_neg(h);
    drive(w32, 1'b0); wait_neg(l);
  endtask

  task automatic send_bit(input bit w32, input logic b);
    if (b) send_hl(w32, 62, 30); else send_hl(w32, 28, 62);
  endtask

  // Sends the low n bits of d, MSB first.
  task automatic send_bits(input bit w32, input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w32, d[i]);
  endtask

  task automatic push_exp(input logic f, input logic [BPP-1:0] d);
    sb.push_back({f, d});
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_data"},  pix_data, 0);
    check({pfx, "_first"}, pix_first, 0);
    check({pfx, "_valid"}, pix_valid, 0);
    check({pfx, "_sr"},    stream_reset, 0);
    check({pfx, "_berr"},  bit_err, 0);
    check({pfx, "_ovf"},   overflow, 0);
  endtask

  initial begin
    int lat, v0, s0, b0, o0, t0;
    logic [BPP-1:0] w [5];
    w[0] = 24'h010203; w[1] = 24'hFEDCBA; w[2] = 24'h00FF00; w[3] = 24'h7E57A1; w[4] = 24'h999999;

    // Reset state
    pix_ready = 1'b1;
    wait_neg(3);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    wait_neg(2);

    // Basic word, latency, single valid cycle, first flag
    v0 = n_v;
    push_exp(1'b1, 24'hA5C3F0);
    send_bits(0, 32'h52E1F8, 23);           // 0xA5C3F0 >> 1
    drive(0, 1'b1); wait_neg(28); drive(0, 1'b0);
    lat = 0;
    while (!pix_valid && lat < 20) begin @(negedge clk); lat++; end
    check("latency", lat, SYNC + 2);
    wait_neg(62 - lat);
    check("one_valid_cycle", n_v - v0, 1);
    push_exp(1'b0, 24'h123456);
    send_bits(0, 32'h123456, 24);
    wait_neg(10);

    // Threshold sweep: 56 -> 0, 57 -> 1, 24 -> 0
    push_exp(1'b0, {3'b010, 21'h15A5A5});
    send_hl(0, 56, 62); send_hl(0, 57, 62); send_hl(0, 24, 62);
    send_bits(0, 32'h15A5A5, 21);
    wait_neg(10);

    // Glitch -> resync; only a stream reset recovers
    b0 = n_berr; s0 = n_sr;
    send_hl(0, 23, 62);
    send_bits(0, 32'h7FFFFF, 23);
    wait_neg(SRC + 100);
    check("glitch_berr", n_berr - b0, 1);
    check("glitch_sr", n_sr - s0, 1);
    push_exp(1'b1, 24'h5A0FF1);
    send_bits(0, 32'h5A0FF1, 24);
    wait_neg(10);

    // Partial word then long low
    s0 = n_sr;
    send_bits(0, 32'h0AB, 9);
    drive(0, 1'b1); wait_neg(62); drive(0, 1'b0);
    t0 = cyc;
    wait_neg(6000);
    check("low_hold_sr_count", n_sr - s0, 1);
    check("low_hold_sr_time", sr_cyc - t0, SRC + SYNC + 1);

    // Partial word then long high
    s0 = n_sr;
    send_bits(0, 32'h155, 10);
    drive(0, 1'b1);
    t0 = cyc;
    wait_neg(6000);
    drive(0, 1'b0);
    wait_neg(100);
    check("high_hold_sr_count", n_sr - s0, 1);
    check("high_hold_sr_time", sr_cyc - t0, SRC + SYNC + 1);
    push_exp(1'b1, 24'hC0FFEE);
    send_bits(0, 32'hC0FFEE, 24);
    wait_neg(10);

    // Backpressure: W0..W3 fill the FIFO, W4 overflows
    pix_ready = 1'b0;
    o0 = n_ovf;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, w[i]);
      send_bits(0, 32'(w[i]), 24);
    end
    wait_neg(5);
    check("no_ovf_at_w3", n_ovf - o0, 0);
    send_bits(0, 32'(w[4]), 24);
    check("ovf_at_w4", n_ovf - o0, 1);

    // Full FIFO: push and pop in the same cycle, so no overflow
    push_exp(1'b0, 24'h2468AD);
    send_bits(0, 32'h123456, 23);           // 0x2468AD >> 1
    drive(0, 1'b1); wait_neg(62); drive(0, 1'b0);
    wait_neg(SYNC + 1);
    pix_ready = 1'b1;
    wait_neg(1);
    pix_ready = 1'b0;
    wait_neg(5);
    check("full_push_pop_no_ovf", n_ovf - o0, 1);
    pix_ready = 1'b1;
    wait_neg(30);
    check("drained", sb.size(), 0);

    // Asynchronous reset mid-cycle with a word queued and a partial word
    pix_ready = 1'b0;
    send_bits(0, 32'h0F0F0F, 24);
    wait_neg(5);
    check("prefill_valid", pix_valid, 1);
    send_bits(0, 32'hABC, 12);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pix_ready = 1'b1;
    wait_neg(2);
    push_exp(1'b1, 24'h3C5AA5);
    send_bits(0, 32'h3C5AA5, 24);
    wait_neg(10);

    // 32-bit instance: one full word, then a 24-bit burst that is discarded
    v0 = n_v32;
    send_bits(1, 32'h11223344, 32);
    wait_neg(10);
    check("w32_count", n_v32 - v0, 1);
    check("w32_word", last32, {1'b1, 32'h11223344});
    s0 = n_sr32;
    send_bits(1, 32'hABCDEF, 24);
    wait_neg(SRC + 100);
    check("w32_burst_no_word", n_v32 - v0, 1);
    check("w32_burst_sr", n_sr32 - s0, 1);

    check("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
